debug_capture_sched: RTL and testbench
======================================

# debug_capture_sched

Round-robin capture scheduler for the SpaceWire debug path. Up to NUM_SRC debug sources each present a DATA_W-bit word with a one-cycle sample strobe. The block buffers one word per source, arbitrates fairly among them, and delivers one tagged word at a time over a valid/ready port to the downstream capture/AXI write stage. Per-source overflow flags and drop counters tell the debug host when words were lost.

## Interface
- NUM_SRC, 4, number of capture sources (2..8)
- DATA_W, 14, debug word width
- SRC_W, $clog2(NUM_SRC), source-id width
- CNT_W, 8, drop counter width per source

- clock_50  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- capture_en  in  1  1 = accept strobes; 0 = ignore new strobes, drain buffered words
- clear_stats  in  1  one-cycle pulse; clears overflow and drop_count
- src_strobe  in  NUM_SRC  bit i = sample src_data word i this cycle
- src_data  in  NUM_SRC*DATA_W  word i at [i*DATA_W +: DATA_W]
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_data  out  DATA_W  captured word
- out_src  out  SRC_W  index of source that produced out_data
- overflow  out  NUM_SRC  sticky per-source word-lost flag
- drop_count  out  NUM_SRC*CNT_W  saturating per-source lost-word count

## Operation
- Per source: one pending register (data plus full bit).
- Output register: out_data, out_src, out_valid. "Free" = !out_valid | out_ready.
- Arbitration: when the output is free and at least one pending register is full, grant the first full source searching from (last_grant+1) mod NUM_SRC upward with wrap. On that edge: load the output, clear that pending register, update last_grant. When the output is not free, no grant, and last_grant holds.
- Strobe i with capture_en=1:
  - pending i empty, or pending i granted on this edge: load src_data i, set full.
  - otherwise: the word is dropped, overflow[i] is set, and drop_count[i] increments, saturating at 2^CNT_W-1. The buffered word is kept (oldest-wins).
- Strobes with capture_en=0: ignored and not counted. Buffered words still drain.
- clear_stats: zeroes overflow and drop_count on that edge. A drop in the same cycle is lost, so the clear wins. Buffers are unaffected.
- Valid/ready: once out_valid=1, out_data and out_src stay stable until accepted. out_valid is never withdrawn without acceptance.

## Timing
- Reset (sync, high): out_valid=0, out_data=0, out_src=0, all pending empty, overflow=0, drop_count=0, last_grant=NUM_SRC-1 (so source 0 has first priority). Reset mid-transfer discards all buffered and output words.
- Latency: strobe at edge N sets pending at N. With the output free, out_valid rises at edge N+1 (2 cycles strobe-to-valid).
- Throughput: 1 word/cycle when out_ready is held high.
- Fairness: when all sources are continuously pending, each is granted once every NUM_SRC accepted transfers.
- A sustained strobe on one source under full backpressure drops every strobe after the first.

## Structure
- Package debug_capture_pkg: DATA_W, NUM_SRC, CNT_W, SRC_W constants and a function for the saturating increment.
- Sub-module rr_arbiter: purely combinational. Inputs are the request vector and last_grant; outputs are the one-hot grant, grant index and any_grant. The top module owns the last_grant register.
- The top module holds the pending registers, output register and stats counters.

## Test plan
- Reset: hold reset 2 cycles with strobes active -> all outputs 0. After release, a strobe on src 2 with data 0x1ABC gives out_valid at +2 cycles with out_data=0x1ABC and out_src=2.
- Round-robin: preload all 4 sources (0x0001..0x0004) with out_ready=0, then raise out_ready -> out_src sequence 0,1,2,3 on consecutive cycles. Refill all and drain again -> sequence continues 0,1,2,3.
- Backpressure/drop: out_ready=0, strobe src 1 five times with distinct data -> first word retained and delivered. drop_count[1]=4 (src 1 strobes 2–5 are dropped; the first strobe's word is the one retained), overflow[1]=1.
- Same-edge refill: src 0 pending and granted while src 0 strobes 0x0222 -> no drop, and 0x0222 is delivered next.
- Saturation and clear: 300 drops on src 3 -> drop_count[3]=255. A clear_stats pulse coincident with a further drop -> count 0, overflow[3]=0.
- capture_en=0 with strobes on all sources -> no words and no drops. Words buffered before capture_en fell are still delivered.

Source files
------------

// File: rtl/debug_capture_sched_pkg.sv
// debug_capture_pkg: shared sizing constants and saturating counter helper for the debug capture scheduler
package debug_capture_pkg;
  localparam int NUM_SRC = 4;
  localparam int DATA_W = 14;
  localparam int CNT_W = 8;
  localparam int SRC_W = $clog2(NUM_SRC);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/debug_capture_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the source after last_i
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   last_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SRC_W-1:0]   idx_o,
  output logic               any_o
);
  // first requester at (last+1) mod NUM_SRC onward wins; the last-granted source is checked last
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!any_o && req_i[SRC_W'((int'(last_i) + k) % NUM_SRC)]) begin
        any_o = 1'b1;
        idx_o = SRC_W'((int'(last_i) + k) % NUM_SRC);
        gnt_o[SRC_W'((int'(last_i) + k) % NUM_SRC)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/debug_capture_sched.sv
// debug_capture_sched: one-deep per-source buffers, round-robin onto a valid/ready port, with drop stats
module debug_capture_sched
  import debug_capture_pkg::*;
#(
  parameter int NUM_SRC = debug_capture_pkg::NUM_SRC,
  parameter int DATA_W = debug_capture_pkg::DATA_W,
  parameter int SRC_W = $clog2(NUM_SRC)
) (
  input  logic                      clock_50,
  input  logic                      reset,
  input  logic                      capture_en,
  input  logic                      clear_stats,
  input  logic [NUM_SRC-1:0]        src_strobe,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic [NUM_SRC-1:0]        overflow,
  output logic [NUM_SRC*CNT_W-1:0]  drop_count
);
  logic [NUM_SRC-1:0] full_q, full_d, ovf_q, ovf_d, gnt, load, drop;
  logic [DATA_W-1:0]  pend_q [NUM_SRC];
  logic [DATA_W-1:0]  pend_d [NUM_SRC];
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic [SRC_W-1:0]   last_q, gnt_idx, out_src_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q, any_gnt, take;

  assign take = (!out_valid_q || out_ready) && any_gnt;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_src = out_src_q;
  assign overflow = ovf_q;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_arb (
    .req_i (full_q),
    .last_i(last_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_gnt)
  );

  // a slot being granted this edge can take a new word on the same edge; otherwise a full slot keeps its old word
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign load[i] = capture_en && src_strobe[i] && (!full_q[i] || (take && gnt[i]));
    assign drop[i] = capture_en && src_strobe[i] && !load[i];
    assign full_d[i] = load[i] || (full_q[i] && !(take && gnt[i]));
    assign pend_d[i] = load[i] ? src_data[i*DATA_W +: DATA_W] : pend_q[i];
    assign ovf_d[i] = !clear_stats && (drop[i] || ovf_q[i]);
    assign cnt_d[i] = clear_stats ? '0 : drop[i] ? sat_inc(cnt_q[i]) : cnt_q[i];
    assign drop_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  // state update: buffers, stats, and the output register which only reloads when free
  always_ff @(posedge clock_50) begin
    if (reset) begin
      full_q <= '0;
      ovf_q <= '0;
      pend_q <= '{default: '0};
      cnt_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= '0;
      last_q <= SRC_W'(NUM_SRC - 1);
    end else begin
      full_q <= full_d;
      ovf_q <= ovf_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      out_valid_q <= take || (out_valid_q && !out_ready);
      if (take) begin
        out_data_q <= pend_q[gnt_idx];
        out_src_q <= gnt_idx;
        last_q <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_debug_capture_sched.sv
// tb_debug_capture_sched: directed checks of reset, round-robin order, drops, same-edge refill, saturation, capture gating
module tb_debug_capture_sched;
  localparam int N = 4;
  localparam int DW = 14;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset, capture_en, clear_stats, out_ready, out_valid;
  logic [N-1:0] src_strobe, overflow;
  logic [N*DW-1:0] src_data;
  logic [DW-1:0] out_data;
  logic [1:0] out_src;
  logic [N*CW-1:0] drop_count;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_capture_sched dut (
    .clock_50   (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .clear_stats(clear_stats),
    .src_strobe (src_strobe),
    .src_data   (src_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    src_data[i*DW +: DW] = v;
  endtask

  function automatic logic [CW-1:0] dc(input int i);
    return drop_count[i*CW +: CW];
  endfunction

  initial begin
    reset = 1'b1;
    capture_en = 1'b1;
    clear_stats = 1'b0;
    out_ready = 1'b0;
    src_strobe = '1;
    src_data = '1;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_count, 0);
    reset = 1'b0;
    src_strobe = '0;
    tick();
    chk("idle_valid", out_valid, 0);
    set_word(2, 14'h1ABC);
    src_strobe = 4'b0100;
    tick();
    src_strobe = '0;
    chk("lat_valid_n", out_valid, 0);
    tick();
    chk("lat_valid_n1", out_valid, 1);
    chk("lat_data", out_data, 14'h1ABC);
    chk("lat_src", out_src, 2);
    out_ready = 1'b1;
    tick();
    chk("lat_drain", out_valid, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, DW'(i + 1));
    src_strobe = '1;
    tick();
    src_strobe = '0;
    tick();
    chk("rr_first_src", out_src, 0);
    chk("rr_first_data", out_data, 1);
    out_ready = 1'b1;
    for (int k = 1; k < N; k++) begin
      tick();
      chk("rr_src", out_src, k);
      chk("rr_data", out_data, k + 1);
    end
    tick();
    chk("rr_empty", out_valid, 0);
    for (int i = 0; i < N; i++) set_word(i, DW'(i + 5));
    src_strobe = '1;
    tick();
    src_strobe = '0;
    tick();
    for (int k = 0; k < N; k++) begin
      chk("rr2_valid", out_valid, 1);
      chk("rr2_src", out_src, k);
      chk("rr2_data", out_data, k + 5);
      tick();
    end
    chk("rr2_empty", out_valid, 0);

    out_ready = 1'b0;
    set_word(0, 14'h00AA);
    src_strobe = 4'b0001;
    tick();
    src_strobe = '0;
    tick();
    src_strobe = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      set_word(1, DW'(14'h100 + k));
      tick();
    end
    src_strobe = '0;
    chk("bp_drop1", dc(1), 4);
    chk("bp_drop0", dc(0), 0);
    chk("bp_ovf", overflow, 4'b0010);
    chk("bp_hold_data", out_data, 14'h00AA);
    chk("bp_hold_src", out_src, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_kept_valid", out_valid, 1);
    chk("bp_kept_src", out_src, 1);
    chk("bp_kept_data", out_data, 14'h101);
    tick();
    chk("bp_empty", out_valid, 0);

    set_word(0, 14'h0111);
    src_strobe = 4'b0001;
    tick();
    set_word(0, 14'h0222);
    tick();
    src_strobe = '0;
    chk("refill_data", out_data, 14'h0111);
    chk("refill_src", out_src, 0);
    chk("refill_nodrop", dc(0), 0);
    chk("refill_ovf", overflow, 4'b0010);
    tick();
    chk("refill_next_valid", out_valid, 1);
    chk("refill_next_data", out_data, 14'h0222);
    chk("refill_next_src", out_src, 0);
    tick();
    chk("refill_empty", out_valid, 0);

    out_ready = 1'b0;
    set_word(3, 14'h0333);
    src_strobe = 4'b1000;
    repeat (302) tick();
    chk("sat_count", dc(3), 255);
    chk("sat_ovf", overflow, 4'b1010);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    src_strobe = '0;
    chk("clr_count", dc(3), 0);
    chk("clr_all", drop_count, 0);
    chk("clr_ovf", overflow, 0);
    out_ready = 1'b1;
    tick();
    chk("sat_drain_valid", out_valid, 1);
    chk("sat_drain_src", out_src, 3);
    chk("sat_drain_data", out_data, 14'h0333);
    tick();
    chk("sat_empty", out_valid, 0);

    out_ready = 1'b0;
    set_word(2, 14'h0BEE);
    src_strobe = 4'b0100;
    tick();
    capture_en = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, 14'h0777);
    src_strobe = '1;
    repeat (3) tick();
    chk("cen_valid", out_valid, 1);
    chk("cen_data", out_data, 14'h0BEE);
    chk("cen_src", out_src, 2);
    chk("cen_drops", drop_count, 0);
    chk("cen_ovf", overflow, 0);
    out_ready = 1'b1;
    tick();
    chk("cen_drain", out_valid, 0);
    tick();
    chk("cen_nowords", out_valid, 0);
    src_strobe = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
